id_stage_pipelined: RTL and testbench
=====================================

// Module: id_stage_pipelined
// PURPOSE
//  Pipelined successor of the single-cycle decode block. Holds the register file, sign/zero extension,
//  control decode and the ID/EX pipeline register. Detects load-use hazards itself and stalls the
//  front end. Inserts bubbles on stall or flush. Keeps the conditional-move write gating on write-back.
//  Sits between the IF/ID register and the execute stage of the 5-stage MIPS datapath.
// PARAMETERS
//  DATA_W    32  datapath / register width
//  NUM_REGS  32  architectural registers; REG_AW = $clog2(NUM_REGS); register 0 reads as 0
//  CTRL_W    16  width of packed control word (field layout in shared package)
//  CNT_W     16  width of saturating stall-cycle counter
// PORTS
//  Clk              in   1        clock, all state on rising edge
//  Reset            in   1        synchronous, active-high
//  IfId_Valid       in   1        IF/ID holds a real instruction
//  IfId_Instruction in   32       instruction word
//  IfId_PCPlus4     in   DATA_W   PC+4 of that instruction
//  Flush            in   1        branch/jump resolved taken in EX; kill instruction entering ID/EX
//  WB_RegWrite      in   1        write-back write request
//  WB_Move          in   1        conditional-move qualifier; write only if WB_RegWrite & WB_Move
//  WB_WriteRegister in   REG_AW   write-back destination
//  WB_WriteData     in   DATA_W   write-back data
//  Stall            out  1        combinational; hold PC and IF/ID this cycle
//  IdEx_Valid       out  1        ID/EX holds a real instruction
//  IdEx_ReadData1   out  DATA_W   rs value
//  IdEx_ReadData2   out  DATA_W   rt value
//  IdEx_Imm         out  DATA_W   extended immediate
//  IdEx_Rs / IdEx_Rt / IdEx_Rd  out  REG_AW  register specifiers, for EX forwarding
//  IdEx_Ctrl        out  CTRL_W   packed control word
//  IdEx_PCPlus4     out  DATA_W   forwarded PC+4
//  StallCount       out  CNT_W    saturating count of stall cycles since reset
// BEHAVIOUR
//  Reset: all IdEx_* = 0, IdEx_Valid = 0, StallCount = 0, all registers cleared to 0. Stall = 0 while Reset.
//  Register file: 2 async read ports (rs = [25:21], rt = [20:16]) and 1 sync write port.
//   - Write enable = WB_RegWrite & WB_Move & (WB_WriteRegister != 0).
//   - Write-first bypass: a same-cycle read of the register being written returns WB_WriteData.
//   - Register 0 always reads 0, bypass included.
//  Immediate: opcode ANDI/ORI/XORI (0x0C/0x0D/0x0E) zero-extend [15:0]; LUI gives {imm,16'b0};
//   all other opcodes sign-extend.
//  Hazard (combinational):
//   Stall = IfId_Valid & IdEx_Valid & Ctrl(IdEx).MemRead & (IdEx_Rt != 0)
//           & (IdEx_Rt == rs | (IdEx_Rt == rt & uses_rt)) & ~Flush & ~Reset.
//   uses_rt comes from the control decode: R-type, stores and branches.
//  ID/EX update each cycle, priority Reset > Flush > Stall > normal:
//   - Flush: IdEx_Valid <= 0, IdEx_Ctrl <= 0. Other fields don't-care but must be written 0.
//   - Stall: bubble (as for Flush). IF/ID is held externally, so the stalled instruction is
//     re-decoded next cycle with fresh register reads. Exactly 1 bubble per load-use.
//   - Normal: capture all fields. IdEx_Valid <= IfId_Valid. Ctrl forced to 0 when ~IfId_Valid.
//  Latency: one cycle from IF/ID to IdEx_*.
//  Flush + hazard in the same cycle: Flush wins and Stall = 0.
//  StallCount increments on every cycle with Stall = 1 and saturates at all-ones (no wrap).
// STRUCTURE
//  Package mips_pkg holds: opcode/funct localparams, ctrl_t packed struct and its CTRL_W,
//   field accessors (MemRead, RegWrite, MemWrite, ALUSrc, RegDst, Branch, HiLoWrite, Madd,
//   Msub, MemToReg, HiOrLo, HiToReg, DontMove, MoveOnNotZero, uses_rt).
//  Sub-module id_ctrl_decode: pure combinational, instruction -> ctrl_t.
//  Register file, extension, hazard logic and ID/EX register are all inline.
// TESTING
//  1. Bypass: WB writes r5=0xDEADBEEF (Move=1) while ID reads rs=r5 -> IdEx_ReadData1=0xDEADBEEF next cycle.
//  2. Move gating: WB_RegWrite=1, WB_Move=0 to r7 -> r7 unchanged. Write to r0 -> r0 reads 0.
//  3. Load-use: lw r8 in ID/EX, add r9,r8,r1 in IF/ID -> Stall=1 for 1 cycle, one bubble
//     (IdEx_Valid=0), then the add issues. StallCount=1.
//  4. Flush+hazard: same setup as 3 plus Flush=1 -> Stall=0, IdEx_Valid=0, StallCount unchanged.
//  5. Immediate: ori 0x8000 -> 0x00008000; addi 0x8000 -> 0xFFFF8000; lui 0x1234 -> 0x12340000.
//  6. Reset mid-stall: assert Reset during case 3 -> next cycle all outputs 0, Stall=0, regs read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct codes, packed control word layout and its field accessors
//   shared by the decode stage and anything downstream that unpacks IdEx_Ctrl.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_LBU      = 6'h24;
    localparam logic [5:0] OP_LHU      = 6'h25;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MOVZ  = 6'h0A;
    localparam logic [5:0] FN_MOVN  = 6'h0B;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_MADD  = 6'h00;
    localparam logic [5:0] FN_MSUB  = 6'h04;

    // dont_move = 1 marks an unconditional register write; movz/movn clear it
    // and EX resolves the condition into WB_Move.
    typedef struct packed {
        logic spare;
        logic uses_rt;
        logic move_on_not_zero;
        logic dont_move;
        logic hi_to_reg;
        logic hi_or_lo;
        logic mem_to_reg;
        logic msub;
        logic madd;
        logic hilo_write;
        logic branch;
        logic reg_dst;
        logic alu_src;
        logic mem_write;
        logic reg_write;
        logic mem_read;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic ctrl_mem_read(ctrl_t c);         return c.mem_read;         endfunction
    function automatic logic ctrl_reg_write(ctrl_t c);        return c.reg_write;        endfunction
    function automatic logic ctrl_mem_write(ctrl_t c);        return c.mem_write;        endfunction
    function automatic logic ctrl_alu_src(ctrl_t c);          return c.alu_src;          endfunction
    function automatic logic ctrl_reg_dst(ctrl_t c);          return c.reg_dst;          endfunction
    function automatic logic ctrl_branch(ctrl_t c);           return c.branch;           endfunction
    function automatic logic ctrl_hilo_write(ctrl_t c);       return c.hilo_write;       endfunction
    function automatic logic ctrl_madd(ctrl_t c);             return c.madd;             endfunction
    function automatic logic ctrl_msub(ctrl_t c);             return c.msub;             endfunction
    function automatic logic ctrl_mem_to_reg(ctrl_t c);       return c.mem_to_reg;       endfunction
    function automatic logic ctrl_hi_or_lo(ctrl_t c);         return c.hi_or_lo;         endfunction
    function automatic logic ctrl_hi_to_reg(ctrl_t c);        return c.hi_to_reg;        endfunction
    function automatic logic ctrl_dont_move(ctrl_t c);        return c.dont_move;        endfunction
    function automatic logic ctrl_move_on_not_zero(ctrl_t c); return c.move_on_not_zero; endfunction
    function automatic logic ctrl_uses_rt(ctrl_t c);          return c.uses_rt;          endfunction

endpackage

// File: rtl/id_ctrl_decode.sv
// id_ctrl_decode: combinational opcode/funct -> packed control word.
//   op    in  6       instruction [31:26]
//   funct in  6       instruction [5:0]
//   ctrl  out ctrl_t  decoded control word
module id_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (op)
            OP_RTYPE: begin
                ctrl.uses_rt          = 1'b1;
                ctrl.reg_dst          = 1'b1;
                ctrl.reg_write        = !(funct inside {FN_JR, FN_MULT, FN_MULTU, FN_MTHI, FN_MTLO});
                ctrl.hilo_write       = funct inside {FN_MULT, FN_MULTU, FN_MTHI, FN_MTLO};
                ctrl.hi_to_reg        = funct inside {FN_MFHI, FN_MFLO};
                ctrl.hi_or_lo         = funct inside {FN_MFHI, FN_MTHI};
                ctrl.dont_move        = !(funct inside {FN_MOVZ, FN_MOVN});
                ctrl.move_on_not_zero = funct == FN_MOVN;
            end
            OP_SPECIAL2: begin
                ctrl.uses_rt    = 1'b1;
                ctrl.hilo_write = funct inside {FN_MADD, FN_MSUB};
                ctrl.madd       = funct == FN_MADD;
                ctrl.msub       = funct == FN_MSUB;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl.mem_read   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.dont_move  = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch  = 1'b1;
                ctrl.uses_rt = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.dont_move = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: MIPS decode stage with register file, immediate extension,
//   load-use hazard detection and the ID/EX pipeline register.
//   Clk, Reset                     clock, synchronous active-high reset
//   IfId_Valid/Instruction/PCPlus4 instruction arriving from IF/ID
//   Flush                          kill the instruction entering ID/EX
//   WB_RegWrite/Move/WriteRegister/WriteData  write-back port (gated by Move)
//   Stall                          combinational front-end hold request
//   IdEx_*                         registered decode results for EX
//   StallCount                     saturating count of stall cycles
module id_stage_pipelined
    import mips_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    parameter  int CNT_W    = 16,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IfId_Valid,
    input  logic [31:0]       IfId_Instruction,
    input  logic [DATA_W-1:0] IfId_PCPlus4,
    input  logic              Flush,
    input  logic              WB_RegWrite,
    input  logic              WB_Move,
    input  logic [REG_AW-1:0] WB_WriteRegister,
    input  logic [DATA_W-1:0] WB_WriteData,
    output logic              Stall,
    output logic              IdEx_Valid,
    output logic [DATA_W-1:0] IdEx_ReadData1,
    output logic [DATA_W-1:0] IdEx_ReadData2,
    output logic [DATA_W-1:0] IdEx_Imm,
    output logic [REG_AW-1:0] IdEx_Rs,
    output logic [REG_AW-1:0] IdEx_Rt,
    output logic [REG_AW-1:0] IdEx_Rd,
    output logic [CTRL_W-1:0] IdEx_Ctrl,
    output logic [DATA_W-1:0] IdEx_PCPlus4,
    output logic [CNT_W-1:0]  StallCount
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [5:0]        op;
    logic [15:0]       imm16;
    logic [REG_AW-1:0] rs, rt, rd;
    logic              we, zext, bubble;
    logic [DATA_W-1:0] rd1, rd2, imm;
    ctrl_t             dec, idex_ctrl;

    assign op    = IfId_Instruction[31:26];
    assign rs    = IfId_Instruction[21 +: REG_AW];
    assign rt    = IfId_Instruction[16 +: REG_AW];
    assign rd    = IfId_Instruction[11 +: REG_AW];
    assign imm16 = IfId_Instruction[15:0];

    id_ctrl_decode u_dec (
        .op    (op),
        .funct (IfId_Instruction[5:0]),
        .ctrl  (dec)
    );

    // Conditional moves only commit when EX resolved the condition true.
    assign we = WB_RegWrite & WB_Move & (WB_WriteRegister != '0);

    always_ff @(posedge Clk)
        if (Reset)
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        else if (we)
            regs[WB_WriteRegister] <= WB_WriteData;

    // Write-first bypass; we is already false for r0, so r0 stays 0.
    assign rd1 = (rs == '0) ? '0 : (we && WB_WriteRegister == rs) ? WB_WriteData : regs[rs];
    assign rd2 = (rt == '0) ? '0 : (we && WB_WriteRegister == rt) ? WB_WriteData : regs[rt];

    assign zext = op inside {OP_ANDI, OP_ORI, OP_XORI};
    assign imm  = zext           ? DATA_W'(imm16) :
                  (op == OP_LUI) ? DATA_W'({imm16, 16'h0000}) :
                                   {{(DATA_W-16){imm16[15]}}, imm16};

    // A load in EX cannot forward in time to a dependent instruction in ID.
    assign Stall = IfId_Valid & IdEx_Valid & ctrl_mem_read(idex_ctrl) & (IdEx_Rt != '0)
                 & ((IdEx_Rt == rs) | ((IdEx_Rt == rt) & ctrl_uses_rt(dec)))
                 & ~Flush & ~Reset;

    assign bubble    = Reset | Flush | Stall;
    assign IdEx_Ctrl = idex_ctrl;

    always_ff @(posedge Clk)
        if (bubble) begin
            IdEx_Valid     <= 1'b0;
            idex_ctrl      <= '0;
            IdEx_ReadData1 <= '0;
            IdEx_ReadData2 <= '0;
            IdEx_Imm       <= '0;
            IdEx_Rs        <= '0;
            IdEx_Rt        <= '0;
            IdEx_Rd        <= '0;
            IdEx_PCPlus4   <= '0;
        end else begin
            IdEx_Valid     <= IfId_Valid;
            idex_ctrl      <= IfId_Valid ? dec : '0;
            IdEx_ReadData1 <= rd1;
            IdEx_ReadData2 <= rd2;
            IdEx_Imm       <= imm;
            IdEx_Rs        <= rs;
            IdEx_Rt        <= rt;
            IdEx_Rd        <= rd;
            IdEx_PCPlus4   <= IfId_PCPlus4;
        end

    always_ff @(posedge Clk)
        if (Reset)
            StallCount <= '0;
        else if (Stall && StallCount != '1)
            StallCount <= StallCount + 1'b1;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb_id_stage_pipelined: scoreboard bench for id_stage_pipelined against an ISA-level model.
module tb_id_stage_pipelined;
    import mips_pkg::*;

    localparam int CW = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1, IfId_Valid = 1'b0, Flush = 1'b0, WB_RegWrite = 1'b0, WB_Move = 1'b0;
    logic [31:0] IfId_Instruction = '0, IfId_PCPlus4 = '0, WB_WriteData = '0;
    logic [4:0]  WB_WriteRegister = '0;
    logic        Stall, IdEx_Valid;
    logic [31:0] IdEx_ReadData1, IdEx_ReadData2, IdEx_Imm, IdEx_PCPlus4;
    logic [4:0]  IdEx_Rs, IdEx_Rt, IdEx_Rd;
    logic [15:0] IdEx_Ctrl;
    logic [CW-1:0] StallCount;

    id_stage_pipelined #(.CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .IfId_Valid(IfId_Valid), .IfId_Instruction(IfId_Instruction),
        .IfId_PCPlus4(IfId_PCPlus4), .Flush(Flush), .WB_RegWrite(WB_RegWrite), .WB_Move(WB_Move),
        .WB_WriteRegister(WB_WriteRegister), .WB_WriteData(WB_WriteData), .Stall(Stall),
        .IdEx_Valid(IdEx_Valid), .IdEx_ReadData1(IdEx_ReadData1), .IdEx_ReadData2(IdEx_ReadData2),
        .IdEx_Imm(IdEx_Imm), .IdEx_Rs(IdEx_Rs), .IdEx_Rt(IdEx_Rt), .IdEx_Rd(IdEx_Rd),
        .IdEx_Ctrl(IdEx_Ctrl), .IdEx_PCPlus4(IdEx_PCPlus4), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  op;
    } exp_t;

    exp_t        q[$];
    int          errors = 0, checks = 0;
    logic [31:0] mregs [32];
    logic        m_valid = 1'b0, m_load = 1'b0, last_stall = 1'b0;
    logic [4:0]  m_rt = '0;
    int          m_cnt = 0;
    logic [31:0] cur_ins = '0, cur_pc = '0;
    logic        cur_v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_load(input logic [5:0] op);
        return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction
    function automatic logic is_store(input logic [5:0] op);
        return op inside {6'h28, 6'h29, 6'h2B};
    endfunction
    function automatic logic is_branch(input logic [5:0] op);
        return op inside {6'h04, 6'h05};
    endfunction
    function automatic logic reads_rt(input logic [5:0] op);
        return op == 6'h00 || op == 6'h1C || is_store(op) || is_branch(op);
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ins);
        logic [15:0] i;
        logic [5:0]  op;
        i  = ins[15:0];
        op = ins[31:26];
        if (op inside {6'h0C, 6'h0D, 6'h0E}) return {16'h0000, i};
        if (op == 6'h0F) return {i, 16'h0000};
        return {{16{i[15]}}, i};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] s, t, d);
        return {6'h00, s, t, d, 5'h00, FN_ADD};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] i);
        return {op, s, t, i};
    endfunction

    // One ID cycle: drive at negedge, check Stall, predict what ID/EX holds after the posedge.
    task automatic step(input logic rst, v, input logic [31:0] ins, pc, input logic fl, wre, mv,
                        input logic [4:0] wa, input logic [31:0] wd);
        logic [4:0]  rs, rt;
        logic [5:0]  op;
        logic        we, es;
        exp_t        e;
        @(negedge Clk);
        Reset = rst; IfId_Valid = v; IfId_Instruction = ins; IfId_PCPlus4 = pc; Flush = fl;
        WB_RegWrite = wre; WB_Move = mv; WB_WriteRegister = wa; WB_WriteData = wd;
        cur_ins = ins; cur_pc = pc; cur_v = v;
        #1;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        we = wre && mv && wa != 0;
        es = v && m_valid && m_load && m_rt != 0 && (m_rt == rs || (m_rt == rt && reads_rt(op))) && !fl && !rst;
        chk("stall", {31'b0, Stall}, {31'b0, es});
        last_stall = es;
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = '0;
            m_valid = 1'b0;
            m_cnt   = 0;
        end else begin
            if (es && m_cnt < (1 << CW) - 1) m_cnt++;
            if (fl || es || !v) m_valid = 1'b0;
            else begin
                e.rd1 = (rs == 0) ? 32'h0 : (we && wa == rs) ? wd : mregs[rs];
                e.rd2 = (rt == 0) ? 32'h0 : (we && wa == rt) ? wd : mregs[rt];
                e.imm = imm_of(ins);
                e.pc  = pc;
                e.rs  = rs;
                e.rt  = rt;
                e.rd  = ins[15:11];
                e.op  = op;
                q.push_back(e);
                m_valid = 1'b1;
                m_load  = is_load(op);
                m_rt    = rt;
            end
            if (we) mregs[wa] = wd;
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic fl);
        step(1'b0, 1'b1, ins, 32'h0040_0000 + 32'($urandom_range(0, 255)) * 4, fl, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [4:0]  a, b, d;
        logic [15:0] i;
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        i = 16'($urandom);
        case ($urandom_range(0, 6))
            0: return enc_r(a, b, d);
            1: return enc_i(OP_LW, a, b, i);
            2: return enc_i(OP_SW, a, b, i);
            3: return enc_i(OP_ADDI, a, b, i);
            4: return enc_i(OP_ORI, a, b, i);
            5: return enc_i(OP_LUI, a, b, i);
            default: return enc_i(OP_BEQ, a, b, i);
        endcase
    endfunction

    // Monitor: pops an expectation whenever ID/EX presents a valid instruction.
    initial forever begin
        exp_t  e;
        ctrl_t c;
        @(posedge Clk);
        #1;
        c = ctrl_t'(IdEx_Ctrl);
        chk("stall_count", 32'(StallCount), 32'(m_cnt));
        chk("idex_valid", {31'b0, IdEx_Valid}, {31'b0, m_valid});
        if (!IdEx_Valid) chk("bubble_ctrl", 32'(IdEx_Ctrl), 32'h0);
        else if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: got pc %h expected no instruction", IdEx_PCPlus4);
        end else begin
            e = q.pop_front();
            chk("rd1", IdEx_ReadData1, e.rd1);
            chk("rd2", IdEx_ReadData2, e.rd2);
            chk("imm", IdEx_Imm, e.imm);
            chk("pc", IdEx_PCPlus4, e.pc);
            chk("rs", 32'(IdEx_Rs), 32'(e.rs));
            chk("rt", 32'(IdEx_Rt), 32'(e.rt));
            chk("rd", 32'(IdEx_Rd), 32'(e.rd));
            chk("mem_read", {31'b0, c.mem_read}, {31'b0, is_load(e.op)});
            chk("mem_write", {31'b0, c.mem_write}, {31'b0, is_store(e.op)});
            chk("branch", {31'b0, c.branch}, {31'b0, is_branch(e.op)});
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        // bypass of r5 while it is written
        step(1'b0, 1'b1, enc_r(5'd5, 5'd0, 5'd2), 32'h100, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        // move gating and r0 write suppression
        step(1'b0, 1'b1, enc_r(5'd7, 5'd5, 5'd3), 32'h104, 1'b0, 1'b1, 1'b0, 5'd7, 32'h1111_2222);
        step(1'b0, 1'b1, enc_r(5'd7, 5'd0, 5'd3), 32'h108, 1'b0, 1'b1, 1'b1, 5'd0, 32'h3333_4444);
        step(1'b0, 1'b1, enc_r(5'd0, 5'd7, 5'd3), 32'h10C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b0, 1'b1, enc_i(OP_ADDI, 5'd0, 5'd1, 16'h0042), 32'h110, 1'b0, 1'b1, 1'b1, 5'd1, 32'h0000_0042);
        // load-use: one stall, one bubble, then the add issues
        issue(enc_i(OP_LW, 5'd1, 5'd8, 16'h0004), 1'b0);
        issue(enc_r(5'd8, 5'd1, 5'd9), 1'b0);
        chk("lu_stalled", {31'b0, last_stall}, 32'h1);
        issue(enc_r(5'd8, 5'd1, 5'd9), 1'b0);
        // flush coinciding with a hazard
        issue(enc_i(OP_LW, 5'd1, 5'd8, 16'h0004), 1'b0);
        issue(enc_r(5'd1, 5'd8, 5'd9), 1'b1);
        // immediates
        issue(enc_i(OP_ORI, 5'd0, 5'd2, 16'h8000), 1'b0);
        issue(enc_i(OP_ADDI, 5'd0, 5'd2, 16'h8000), 1'b0);
        issue(enc_i(OP_LUI, 5'd0, 5'd2, 16'h1234), 1'b0);
        // reset in the middle of a load-use stall
        issue(enc_i(OP_LW, 5'd1, 5'd8, 16'h0004), 1'b0);
        issue(enc_r(5'd8, 5'd1, 5'd9), 1'b0);
        step(1'b1, 1'b1, enc_r(5'd8, 5'd1, 5'd9), 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge Clk);
        #2;
        chk("rst_rd1", IdEx_ReadData1, 32'h0);
        chk("rst_pc", IdEx_PCPlus4, 32'h0);
        chk("rst_rs", 32'(IdEx_Rs), 32'h0);
        issue(enc_r(5'd5, 5'd1, 5'd9), 1'b0);
        // drive the counter past saturation
        for (int k = 0; k < 20; k++) begin
            issue(enc_i(OP_LW, 5'd2, 5'd8, 16'h0000), 1'b0);
            issue(enc_i(OP_SW, 5'd3, 5'd8, 16'h0000), 1'b0);
            issue(enc_i(OP_SW, 5'd3, 5'd8, 16'h0000), 1'b0);
        end
        // randomized traffic; a stalled instruction is held and re-presented
        for (int k = 0; k < 800; k++) begin
            logic [31:0] ins, pc;
            logic        v;
            if (last_stall) begin
                ins = cur_ins; pc = cur_pc; v = cur_v;
            end else begin
                ins = rand_ins(); pc = $urandom; v = $urandom_range(0, 7) != 0;
            end
            step($urandom_range(0, 99) == 0, v, ins, pc, $urandom_range(0, 9) == 0,
                 1'($urandom), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
        end
        @(posedge Clk);
        #2;
        chk("drain", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
